register_file_mp: RTL and testbench

Parametrised multi-port integer register file for the five-stage pipeline, replacing the fixed 2-read/1-write file in decode. It provides NUM_READ asynchronous read ports with write-to-read bypass, one synchronous write port from writeback, and a per-register busy scoreboard that decode uses to detect RAW hazards. After reset it sweeps every register to zero, one register per cycle, and holds `ready` low until the sweep completes.

---
 rtl/register_file_mp.sv | 127 ++++++++++++
 tb/tb_register_file_mp.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port integer register file with write-to-read bypass, a busy
// scoreboard for RAW hazard detection, and a post-reset clear sweep.
module register_file_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  output logic                             ready,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   read_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]   read_data,
  output logic [NUM_READ-1:0]              read_busy,
  input  logic                             write_enable,
  input  logic [ADDR_WIDTH-1:0]            write_addr,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             reserve_enable,
  input  logic [ADDR_WIDTH-1:0]            reserve_addr
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam bit BYP_EN  = (BYPASS != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ready_d;
  logic                    sweep_we;
  logic                    run;
  logic                    wr_commit;
  logic                    rsv_commit;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]        busy_q;

  assign run        = (state_q == ST_RUN);
  assign wr_commit  = run && write_enable &&
                      !(ZERO_EN && (write_addr == '0));
  assign rsv_commit = run && reserve_enable &&
                      !(ZERO_EN && (reserve_addr == '0));

  // State, sweep counter and ready flag
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= ready_d;
    end
  end

  // Next state: sweep one register per cycle, then enter RUN
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready;
    sweep_we = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Storage array; reset leaves contents alone, the sweep clears them
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (sweep_we) begin
        mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
      end else if (wr_commit) begin
        mem[write_addr] <= write_data;
      end
    end
  end

  // Busy scoreboard; reserve is applied last so it wins on a same-address edge
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      if (wr_commit) begin
        busy_q[write_addr] <= 1'b0;
      end
      if (rsv_commit) begin
        busy_q[reserve_addr] <= 1'b1;
      end
    end
  end

  // Asynchronous read ports with optional same-cycle bypass
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  zero_hit;
    logic                  byp_hit;

    assign addr     = read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign zero_hit = ZERO_EN && (addr == '0);
    assign byp_hit  = BYP_EN && run && write_enable && (write_addr == addr);

    assign read_data[i*DATA_WIDTH +: DATA_WIDTH] =
      (!run || zero_hit) ? '0 : (byp_hit ? write_data : mem[addr]);
    assign read_busy[i] = run && !zero_hit && !byp_hit && busy_q[addr];
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: dut0 is the default build (2 ports, 32 bit,
// bypass on); dut1 is 4 ports, 64 bit, bypass off. A behavioural model
// predicts every port each cycle; directed pins fix known values.
module tb_register_file_mp;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we  [2];
  logic [4:0]  wa  [2];
  logic [63:0] wd  [2];
  logic        rv  [2];
  logic [4:0]  rva [2];
  logic [4:0]  ra  [2][4];

  logic [9:0]   ra0_bus;
  logic [19:0]  ra1_bus;
  logic         rdy0, rdy1;
  logic [63:0]  rd0_bus;
  logic [255:0] rd1_bus;
  logic [1:0]   rb0;
  logic [3:0]   rb1;

  int  n_checks = 0;
  int  n_fail   = 0;
  logic chk_en  = 1'b0;

  // Behavioural model state
  logic [63:0] m_mem  [2][DEPTH];
  logic        m_busy [2][DEPTH];
  logic        m_ready[2];
  int          m_edges[2];

  logic [63:0] pat [4];

  always #5 clk = ~clk;

  assign ra0_bus = {ra[0][1], ra[0][0]};
  assign ra1_bus = {ra[1][3], ra[1][2], ra[1][1], ra[1][0]};

  register_file_mp dut0 (
    .clock         (clk),
    .reset_n       (rst_n),
    .ready         (rdy0),
    .read_addr     (ra0_bus),
    .read_data     (rd0_bus),
    .read_busy     (rb0),
    .write_enable  (we[0]),
    .write_addr    (wa[0]),
    .write_data    (wd[0][31:0]),
    .reserve_enable(rv[0]),
    .reserve_addr  (rva[0])
  );

  register_file_mp #(
    .DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(4), .ZERO_REG(1), .BYPASS(0)
  ) dut1 (
    .clock         (clk),
    .reset_n       (rst_n),
    .ready         (rdy1),
    .read_addr     (ra1_bus),
    .read_data     (rd1_bus),
    .read_busy     (rb1),
    .write_enable  (we[1]),
    .write_addr    (wa[1]),
    .write_data    (wd[1]),
    .reserve_enable(rv[1]),
    .reserve_addr  (rva[1])
  );

  function automatic logic [63:0] dmask(int d);
    return (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic int nports(int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic logic [63:0] act_data(int d, int p);
    if (d == 0) return {32'h0, rd0_bus[p*32 +: 32]};
    return rd1_bus[p*64 +: 64];
  endfunction

  function automatic logic act_busy(int d, int p);
    return (d == 0) ? rb0[p] : rb1[p];
  endfunction

  // Expected read data from the architectural view of the file
  function automatic logic [63:0] exp_data(int d, int p);
    logic [4:0] a;
    a = ra[d][p];
    if (!m_ready[d] || a == 5'd0) return 64'h0;
    if (d == 0 && we[d] && wa[d] == a) return wd[d] & dmask(d);
    return m_mem[d][a];
  endfunction

  function automatic logic exp_busy(int d, int p);
    logic [4:0] a;
    a = ra[d][p];
    if (!m_ready[d] || a == 5'd0) return 1'b0;
    if (d == 0 && we[d] && wa[d] == a) return 1'b0;
    return m_busy[d][a];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model update: count sweep edges, then apply writes and reservations
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_ready[d] <= 1'b0;
        m_edges[d] <= 0;
        for (int r = 0; r < DEPTH; r++) m_busy[d][r] <= 1'b0;
      end else if (!m_ready[d]) begin
        m_edges[d] <= m_edges[d] + 1;
        if (m_edges[d] == DEPTH - 1) begin
          m_ready[d] <= 1'b1;
          for (int r = 0; r < DEPTH; r++) m_mem[d][r] <= 64'h0;
        end
      end else begin
        if (we[d] && wa[d] != 5'd0) begin
          m_mem[d][wa[d]]  <= wd[d] & dmask(d);
          m_busy[d][wa[d]] <= 1'b0;
        end
        if (rv[d] && rva[d] != 5'd0) m_busy[d][rva[d]] <= 1'b1;
      end
    end
  end

  // Per-cycle comparison of every port against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d_ready", d), {63'h0, (d == 0) ? rdy0 : rdy1}, {63'h0, m_ready[d]});
        for (int p = 0; p < nports(d); p++) begin
          check($sformatf("d%0d_p%0d_data", d, p), act_data(d, p), exp_data(d, p));
          check($sformatf("d%0d_p%0d_busy", d, p), {63'h0, act_busy(d, p)}, {63'h0, exp_busy(d, p)});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
    #1;
  endtask

  task automatic set_write(input logic en, input logic [4:0] a, input logic [63:0] v0, input logic [63:0] v1);
    we[0] = en; we[1] = en;
    wa[0] = a;  wa[1] = a;
    wd[0] = v0; wd[1] = v1;
  endtask

  task automatic set_reserve(input logic en, input logic [4:0] a);
    rv[0] = en; rv[1] = en;
    rva[0] = a; rva[1] = a;
  endtask

  task automatic set_read(input int p, input logic [4:0] a);
    if (p < 2) ra[0][p] = a;
    ra[1][p] = a;
  endtask

  initial begin
    pat[0] = 64'h0123_4567_89AB_CDEF;
    pat[1] = 64'hFEDC_BA98_7654_3210;
    pat[2] = 64'h8000_0000_0000_0001;
    pat[3] = 64'h5A5A_F0F0_0F0F_A5A5;
    m_ready[0] = 1'b0; m_ready[1] = 1'b0;
    m_edges[0] = 0;    m_edges[1] = 0;
    rst_n = 1'b0;
    set_write(1'b0, 5'd0, 64'h0, 64'h0);
    set_reserve(1'b0, 5'd0);
    for (int p = 0; p < 4; p++) set_read(p, 5'd0);

    // Reset for three edges, then the 32-edge sweep
    tick;
    chk_en = 1'b1;
    tick;
    tick;
    settle;
    check("reset_ready", {63'h0, rdy0}, 64'h0);
    check("reset_data", act_data(0, 0), 64'h0);
    rst_n = 1'b1;
    repeat (31) tick;
    settle;
    check("ready_edge31", {63'h0, rdy0}, 64'h0);
    tick;
    settle;
    check("ready_edge32", {63'h0, rdy0}, 64'h1);
    check("ready_edge32_d1", {63'h0, rdy1}, 64'h1);
    tick;

    // Preload junk, reset again, confirm the sweep cleared it
    set_write(1'b1, 5'd5, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
    tick;
    wa[0] = 5'd3; wa[1] = 5'd3;
    tick;
    set_write(1'b0, 5'd0, 64'h0, 64'h0);
    set_read(0, 5'd5); set_read(1, 5'd3);
    settle;
    check("preload_x5", act_data(0, 0), 64'hDEAD_BEEF);
    check("preload_x3_d1", act_data(1, 1), 64'hDEAD_BEEF);
    tick;
    rst_n = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (31) tick;
    settle;
    check("clear_forced_data", act_data(0, 0), 64'h0);
    tick;
    settle;
    check("swept_x5", act_data(0, 0), 64'h0);
    check("swept_x3", act_data(0, 1), 64'h0);
    check("swept_x5_d1", act_data(1, 0), 64'h0);
    tick;

    // Plain write and dual-port read
    set_read(0, 5'd5); set_read(1, 5'd5);
    set_write(1'b1, 5'd5, 64'h1234_5678, 64'hCAFE_0000_1234_5678);
    tick;
    set_write(1'b0, 5'd0, 64'h0, 64'h0);
    settle;
    check("x5_port0", act_data(0, 0), 64'h1234_5678);
    check("x5_port1", act_data(0, 1), 64'h1234_5678);
    check("x5_busy", {62'h0, rb0}, 64'h0);
    check("x5_d1", act_data(1, 0), 64'hCAFE_0000_1234_5678);
    tick;

    // Register 0 stays zero
    set_read(0, 5'd0); set_read(1, 5'd0);
    set_write(1'b1, 5'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    tick;
    set_write(1'b0, 5'd0, 64'h0, 64'h0);
    settle;
    check("x0_zero", act_data(0, 0), 64'h0);
    check("x0_zero_d1", act_data(1, 0), 64'h0);
    tick;

    // Same-cycle bypass (dut0) versus no bypass (dut1)
    set_read(0, 5'd7);
    set_write(1'b1, 5'd7, 64'hA5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5);
    settle;
    check("bypass_on", act_data(0, 0), 64'hA5A5_A5A5);
    check("bypass_off_old", act_data(1, 0), 64'h0);
    tick;
    set_write(1'b0, 5'd0, 64'h0, 64'h0);
    settle;
    check("bypass_off_new", act_data(1, 0), 64'hA5A5_A5A5_A5A5_A5A5);
    tick;

    // Scoreboard: reserve, then write releases it
    set_read(0, 5'd9);
    set_reserve(1'b1, 5'd9);
    settle;
    check("rsv_not_yet", {63'h0, rb0[0]}, 64'h0);
    tick;
    set_reserve(1'b0, 5'd0);
    settle;
    check("rsv_visible", {63'h0, rb0[0]}, 64'h1);
    check("rsv_visible_d1", {63'h0, rb1[0]}, 64'h1);
    tick;
    set_write(1'b1, 5'd9, 64'h1111, 64'h1111);
    settle;
    check("wr_bypass_busy", {63'h0, rb0[0]}, 64'h0);
    check("wr_bypass_data", act_data(0, 0), 64'h1111);
    check("wr_nobypass_busy", {63'h0, rb1[0]}, 64'h1);
    tick;
    set_write(1'b0, 5'd0, 64'h0, 64'h0);
    settle;
    check("wr_released", {63'h0, rb0[0]}, 64'h0);
    check("wr_released_d1", {63'h0, rb1[0]}, 64'h0);
    tick;

    // Reserve and write on the same edge: reserve wins, data still lands
    set_reserve(1'b1, 5'd9);
    set_write(1'b1, 5'd9, 64'h2222, 64'h2222);
    tick;
    set_reserve(1'b0, 5'd0);
    set_write(1'b0, 5'd0, 64'h0, 64'h0);
    settle;
    check("same_edge_busy", {63'h0, rb0[0]}, 64'h1);
    check("same_edge_data", act_data(0, 0), 64'h2222);
    check("same_edge_busy_d1", {63'h0, rb1[0]}, 64'h1);
    tick;

    // Reserving x0 has no effect
    set_read(0, 5'd0);
    set_reserve(1'b1, 5'd0);
    tick;
    set_reserve(1'b0, 5'd0);
    settle;
    check("rsv_x0", {63'h0, rb0[0]}, 64'h0);
    tick;

    // Four distinct 64-bit registers read in one cycle
    for (int i = 0; i < 4; i++) begin
      set_write(1'b1, 5'(i + 1), pat[i], pat[i]);
      tick;
    end
    set_write(1'b0, 5'd0, 64'h0, 64'h0);
    for (int p = 0; p < 4; p++) set_read(p, 5'(p + 1));
    settle;
    for (int p = 0; p < 4; p++) check($sformatf("quad_p%0d", p), act_data(1, p), pat[p]);
    tick;
    for (int p = 0; p < 4; p++) set_read(p, 5'd2);
    settle;
    for (int p = 0; p < 4; p++) check($sformatf("same_reg_p%0d", p), act_data(1, p), pat[1]);
    tick;

    // Reset mid-sweep; writes/reserves during CLEAR are ignored
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    repeat (10) tick;
    rst_n = 1'b0;
    set_write(1'b1, 5'd3, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
    set_reserve(1'b1, 5'd3);
    set_read(0, 5'd3);
    tick;
    rst_n = 1'b1;
    repeat (31) tick;
    settle;
    check("restart_edge31", {63'h0, rdy0}, 64'h0);
    tick;
    set_write(1'b0, 5'd0, 64'h0, 64'h0);
    set_reserve(1'b0, 5'd0);
    settle;
    check("restart_edge32", {63'h0, rdy0}, 64'h1);
    check("clear_ignored_x3", act_data(0, 0), 64'h0);
    check("clear_ignored_busy", {63'h0, rb0[0]}, 64'h0);
    check("clear_ignored_x3_d1", act_data(1, 0), 64'h0);
    tick;

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
